bfly_cmult_seq: RTL

Sequencer for one radix-2 FFT butterfly (X = A + B·W, Y = A − B·W) on complex Q9.6 two's-complement operands. It time-multiplexes a single shared `sign_mult` instance across the four real products of the complex twiddle multiply, then forms the butterfly sums. It sits between the FFT address/twiddle generator (upstream, valid/ready) and the result write-back (downstream, valid/ready).

---
 rtl/bfly_pkg.sv | 21 ++
 rtl/sign_mult.sv | 24 ++
 rtl/bfly_cmult_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bfly_pkg.sv
// Shared types and constants for the radix-2 butterfly sequencer.
package bfly_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 6;

  localparam logic [DATA_W-1:0] Q_ONE     = 16'h0040;
  localparam logic [DATA_W-1:0] Q_NEG_ONE = 16'hFFC0;

  // One state per shared-multiplier pass, then the sum and hand-off states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_SUM,
    ST_DONE
  } bfly_state_t;

endpackage

// File: rtl/sign_mult.sv
// 16x16 Q9.6 multiplier working on magnitudes, result re-signed on the low
// 15 bits. A zero magnitude with differing signs yields 0x8000.
module sign_mult
  import bfly_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);

  logic [14:0] a_mag;
  logic [14:0] b_mag;
  logic [29:0] full;
  logic [14:0] mag;
  logic        sgn;

  assign a_mag = 15'(a[15] ? (~a + 16'd1) : a);
  assign b_mag = 15'(b[15] ? (~b + 16'd1) : b);
  assign full  = {15'd0, a_mag} * {15'd0, b_mag};
  assign mag   = 15'(full >> FRAC_BITS);
  assign sgn   = a[15] ^ b[15];
  assign p     = {sgn, sgn ? (~mag + 15'd1) : mag};

endmodule

// File: rtl/bfly_cmult_seq.sv
// Radix-2 butterfly X = A + B*W, Y = A - B*W. One shared multiplier is
// stepped through the four real products, then the sums are registered.
module bfly_cmult_seq
  import bfly_pkg::*;
#(
  parameter int DATA_W = bfly_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ar,
  input  logic [DATA_W-1:0] ai,
  input  logic [DATA_W-1:0] br,
  input  logic [DATA_W-1:0] bi,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] xr,
  output logic [DATA_W-1:0] xi,
  output logic [DATA_W-1:0] yr,
  output logic [DATA_W-1:0] yi,
  output logic              busy
);

  bfly_state_t state_q, state_d;

  logic [DATA_W-1:0] ar_q, ai_q, br_q, bi_q, wr_q, wi_q;
  logic [DATA_W-1:0] p0_q, p1_q, p2_q, p3_q;
  logic [DATA_W-1:0] mult_a, mult_b, prod, prod_fix;
  logic [DATA_W-1:0] tr, ti;
  logic              accept;

  assign in_ready  = !rst && ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed walk through the products, hand-off in DONE.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_M0;
      ST_M0:   state_d = ST_M1;
      ST_M1:   state_d = ST_M2;
      ST_M2:   state_d = ST_M3;
      ST_M3:   state_d = ST_SUM;
      ST_SUM:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_M0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are always written on
    // accept before any state reads them.
    if (accept) begin
      ar_q <= ar;
      ai_q <= ai;
      br_q <= br;
      bi_q <= bi;
      wr_q <= wr;
      wi_q <= wi;
    end
  end

  // Operand mux feeding the shared multiplier.
  always_comb begin
    mult_a = br_q;
    mult_b = wr_q;
    case (state_q)
      ST_M1: begin mult_a = bi_q; mult_b = wi_q; end
      ST_M2: begin mult_a = br_q; mult_b = wi_q; end
      ST_M3: begin mult_a = bi_q; mult_b = wr_q; end
      default: ;
    endcase
  end

  sign_mult u_mult (
    .a (mult_a),
    .b (mult_b),
    .p (prod)
  );

  // A negative zero from the multiplier becomes a true zero.
  assign prod_fix = (prod[DATA_W-2:0] == '0) ? '0 : prod;

  // Product registers, one per multiplier pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
    end else begin
      case (state_q)
        ST_M0:   p0_q <= prod_fix;
        ST_M1:   p1_q <= prod_fix;
        ST_M2:   p2_q <= prod_fix;
        ST_M3:   p3_q <= prod_fix;
        default: ;
      endcase
    end
  end

  // Twiddle product B*W; all adds wrap at 16 bits.
  assign tr = p0_q - p1_q;
  assign ti = p2_q + p3_q;

  // Butterfly outputs, registered in SUM and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr <= '0;
      xi <= '0;
      yr <= '0;
      yi <= '0;
    end else if (state_q == ST_SUM) begin
      xr <= ar_q + tr;
      xi <= ai_q + ti;
      yr <= ar_q - tr;
      yi <= ai_q - ti;
    end
  end

endmodule
